mult4s_csa_ppg_seq: RTL and testbench
=====================================

MULT4S_CSA_PPG_SEQ -- requirements
Module: mult4s_csa_ppg_seq

Interface
REQ-001 SHALL have parameter SIGNED, default 1, where 1 selects two's-complement operands and 0 selects unsigned operands.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: operand pair valid.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept an operand pair.
REQ-006 SHALL have port in_a, input, 4 bits: multiplicand.
REQ-007 SHALL have port in_b, input, 4 bits: multiplier.
REQ-008 SHALL have port out_valid, output, 1 bit: carry-save result rows valid.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream CPA stage accepts the rows.
REQ-010 SHALL have port out_row0, output, 8 bits: sum row.
REQ-011 SHALL have port out_row1, output, 8 bits: carry row; bit 0 always 0.

Function
REQ-012 SHALL implement states IDLE, ACC, DONE, using a 2-bit partial-product index k.
REQ-013 SHALL drive in_ready=1 only in IDLE; input acceptance occurs on the edge where in_valid&in_ready=1.
REQ-014 SHALL, on acceptance, register a and b, set k=0, set row1=0, and go to ACC.
REQ-015 SHALL, on acceptance, set row0=8'h01 when SIGNED=1 and in_b[3]=1, and set row0=0 otherwise.
REQ-016 SHALL form partial product pp_k as follows: for k<3, or when SIGNED=0, pp_k=(ext(a) AND {8{b[k]}})<<k mod 256, where ext is sign-extension if SIGNED=1 and zero-extension if SIGNED=0.
REQ-017 SHALL form pp_3 when SIGNED=1 as b[3] ? ~(sext(a)<<3) : 8'h00, all mod 256.
REQ-018 SHALL, on each ACC edge, apply a 3:2 compression of pp_k into the rows: row0' = row0^row1^pp_k; row1' = (maj(row0,row1,pp_k)<<1) mod 256; then k increments.
REQ-019 SHALL, on the ACC edge with k=3, go to DONE; latency is 4 edges from acceptance to out_valid=1.
REQ-020 SHALL guarantee that in DONE, (out_row0+out_row1) mod 256 equals the 8-bit product a*b under the SIGNED interpretation.
REQ-021 SHALL guarantee out_row1[0]=0, so that bit 0 passes straight through and the downstream 7-bit CPA adds bits [7:1].
REQ-022 SHALL drive out_valid=1 only in DONE; rows SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, on out_valid&out_ready, return to IDLE; no new operand is accepted in that same cycle.
REQ-024 SHALL ignore in_valid while in ACC or DONE; in_a and in_b changes during that time SHALL NOT affect the result.
REQ-025 SHALL allow out_ready to be high before DONE with no effect.
REQ-026 SHALL, on rst asserted in any state including mid-ACC, go to IDLE on that edge and discard the in-flight operation.

Reset
REQ-027 SHALL, after reset, drive state=IDLE, k=0, out_row0=0, out_row1=0, out_valid=0, in_ready=1.
REQ-028 SHALL give rst priority over any simultaneous input or output handshake.

Verification
REQ-029 SHALL cover this case: SIGNED=1, a=4'b1000 (-8), b=4'b1000 (-8) -> out_valid rises 4 cycles after acceptance; (row0+row1) mod 256 = 8'h40; row1[0]=0.
REQ-030 SHALL cover this case: SIGNED=1, a=7, b=4'b1111 (-1) -> sum = 8'hF9 (-7); SIGNED=1, a=-1, b=-1 -> sum = 8'h01.
REQ-031 SHALL cover this case: SIGNED=0, a=15, b=15 -> sum = 8'hE1 (225); a=0, b=9 -> sum = 8'h00.
REQ-032 SHALL cover this case: backpressure with out_ready=0 for 3 cycles in DONE -> rows and out_valid stable; handshake on cycle 4 -> IDLE with in_ready=1 the next cycle.
REQ-033 SHALL cover this case: rst pulsed at ACC k=2 -> next cycle rows=0, out_valid=0, in_ready=1; a new operation afterwards yields the correct product.
REQ-034 SHALL cover this case: in_valid held high with changing in_a/in_b during ACC -> result matches the originally accepted pair.
REQ-035 SHALL cover exhaustive random operand pairs for both SIGNED values, checking each sum against a reference product.

Source files
------------

// File: rtl/mult4s_csa_ppg_seq.sv
// Sequential 4x4 multiplier: one partial product per cycle is folded into a
// sum/carry row pair by a 3:2 compressor; the final CPA is left downstream.
module mult4s_csa_ppg_seq #(
   parameter bit SIGNED = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_a,
   input  logic [3:0] in_b,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_row0,
   output logic [7:0] out_row1
);

   typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

   state_e     state_q, state_d;
   logic [3:0] a_q, a_d, b_q, b_d;
   logic [1:0] k_q, k_d;
   logic [7:0] row0_q, row0_d, row1_q, row1_d;
   logic       in_ready_q, in_ready_d;
   logic       out_valid_q, out_valid_d;

   logic [7:0] ext_a, sh3_a, pp, maj;

   always_comb begin
      ext_a = SIGNED ? {{4{a_q[3]}}, a_q} : {4'b0000, a_q};
      sh3_a = ext_a << 3;
      pp    = (ext_a & {8{b_q[k_q]}}) << k_q;
      // Negative weight of the sign bit: ~(a<<3), the +1 was preloaded into row0.
      if (SIGNED && (k_q == 2'd3)) begin
         pp = b_q[3] ? ~sh3_a : 8'h00;
      end
      maj = (row0_q & row1_q) | (row0_q & pp) | (row1_q & pp);
   end

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      k_d         = k_q;
      row0_d      = row0_q;
      row1_d      = row1_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d        = in_a;
               b_d        = in_b;
               k_d        = 2'd0;
               row0_d     = (SIGNED && in_b[3]) ? 8'h01 : 8'h00;
               row1_d     = 8'h00;
               in_ready_d = 1'b0;
               state_d    = StAcc;
            end
         end
         StAcc: begin
            row0_d = row0_q ^ row1_q ^ pp;
            row1_d = {maj[6:0], 1'b0};
            k_d    = k_q + 2'd1;
            if (k_q == 2'd3) begin
               out_valid_d = 1'b1;
               state_d     = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = StIdle;
            end
         end
         default: begin
            state_d     = StIdle;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         a_q         <= 4'h0;
         b_q         <= 4'h0;
         k_q         <= 2'd0;
         row0_q      <= 8'h00;
         row1_q      <= 8'h00;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         k_q         <= k_d;
         row0_q      <= row0_d;
         row1_q      <= row1_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_row0  = row0_q;
   assign out_row1  = row1_q;

endmodule

// File: tb/tb_mult4s_csa_ppg_seq.sv
// Bench for mult4s_csa_ppg_seq: signed and unsigned instances run in lockstep
// on shared inputs; the carry-save rows are summed and compared to products.
module tb_mult4s_csa_ppg_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [3:0] in_a, in_b;
   logic       out_ready;

   logic       in_ready_s, out_valid_s, in_ready_u, out_valid_u;
   logic [7:0] row0_s, row1_s, row0_u, row1_u;
   logic [7:0] sum_s, sum_u;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign sum_s = row0_s + row1_s;
   assign sum_u = row0_u + row1_u;

   mult4s_csa_ppg_seq #(.SIGNED(1'b1)) dut_s (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready_s),
      .in_a     (in_a),
      .in_b     (in_b),
      .out_valid(out_valid_s),
      .out_ready(out_ready),
      .out_row0 (row0_s),
      .out_row1 (row1_s)
   );

   mult4s_csa_ppg_seq #(.SIGNED(1'b0)) dut_u (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready_u),
      .in_a     (in_a),
      .in_b     (in_b),
      .out_valid(out_valid_u),
      .out_ready(out_ready),
      .out_row0 (row0_u),
      .out_row1 (row1_u)
   );

   function automatic logic [7:0] ref_prod(input logic [3:0] a, input logic [3:0] b,
                                           input bit sgn);
      int sa, sb, p;
      sa = (sgn && a[3]) ? int'(a) - 16 : int'(a);
      sb = (sgn && b[3]) ? int'(b) - 16 : int'(b);
      p  = sa * sb;
      return p[7:0];
   endfunction

   // Presents one operand pair and waits (bounded) for out_valid; lat counts
   // negedges from the one following the acceptance edge.
   task automatic run_op(input logic [3:0] a, input logic [3:0] b, output int lat);
      @(negedge clk);
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat      = 0;
      while (!out_valid_s && lat < 10) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic release_op();
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_a      = 4'h5;
      in_b      = 4'h5;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      n_checks += 8;
      if (in_ready_s !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_s got %b exp 1", in_ready_s); end
      if (out_valid_s !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid_s got %b exp 0", out_valid_s); end
      if (row0_s !== 8'h00) begin n_fail++; $display("FAIL reset_row0_s got %h exp 00", row0_s); end
      if (row1_s !== 8'h00) begin n_fail++; $display("FAIL reset_row1_s got %h exp 00", row1_s); end
      if (in_ready_u !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_u got %b exp 1", in_ready_u); end
      if (out_valid_u !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid_u got %b exp 0", out_valid_u); end
      if (row0_u !== 8'h00) begin n_fail++; $display("FAIL reset_row0_u got %h exp 00", row0_u); end
      if (row1_u !== 8'h00) begin n_fail++; $display("FAIL reset_row1_u got %h exp 00", row1_u); end
   endtask

   task automatic test_signed_vectors();
      logic [3:0] va [4] = '{4'h8, 4'h7, 4'hF, 4'h3};
      logic [3:0] vb [4] = '{4'h8, 4'hF, 4'hF, 4'hA};
      logic [7:0] ve [4] = '{8'h40, 8'hF9, 8'h01, 8'hEE};  // 3*-6 = -18
      int lat;
      for (int i = 0; i < 4; i++) begin
         run_op(va[i], vb[i], lat);
         n_checks += 3;
         if (lat !== 4) begin n_fail++; $display("FAIL signed_latency[%0d] got %0d exp 4", i, lat); end
         if (sum_s !== ve[i]) begin n_fail++; $display("FAIL signed_sum[%0d] got %h exp %h", i, sum_s, ve[i]); end
         if (row1_s[0] !== 1'b0) begin n_fail++; $display("FAIL signed_row1_lsb[%0d] got %b exp 0", i, row1_s[0]); end
         release_op();
      end
   endtask

   task automatic test_unsigned_vectors();
      logic [3:0] va [4] = '{4'hF, 4'h0, 4'h8, 4'h7};
      logic [3:0] vb [4] = '{4'hF, 4'h9, 4'h8, 4'hF};
      logic [7:0] ve [4] = '{8'hE1, 8'h00, 8'h40, 8'h69};
      int lat;
      for (int i = 0; i < 4; i++) begin
         run_op(va[i], vb[i], lat);
         n_checks += 3;
         if (out_valid_u !== 1'b1) begin n_fail++; $display("FAIL unsigned_valid[%0d] got %b exp 1", i, out_valid_u); end
         if (sum_u !== ve[i]) begin n_fail++; $display("FAIL unsigned_sum[%0d] got %h exp %h", i, sum_u, ve[i]); end
         if (row1_u[0] !== 1'b0) begin n_fail++; $display("FAIL unsigned_row1_lsb[%0d] got %b exp 0", i, row1_u[0]); end
         release_op();
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] r0, r1;
      int lat;
      run_op(4'h3, 4'h5, lat);
      r0 = row0_s;
      r1 = row1_s;
      n_checks++;
      if (sum_s !== 8'h0F) begin n_fail++; $display("FAIL bp_sum got %h exp 0f", sum_s); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks += 3;
         if (out_valid_s !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b exp 1", i, out_valid_s); end
         if (row0_s !== r0) begin n_fail++; $display("FAIL bp_row0[%0d] got %h exp %h", i, row0_s, r0); end
         if (row1_s !== r1) begin n_fail++; $display("FAIL bp_row1[%0d] got %h exp %h", i, row1_s, r1); end
      end
      // A pending operand during the output handshake must not be taken.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_a      = 4'h2;
      in_b      = 4'h2;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      n_checks += 2;
      if (out_valid_s !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b exp 0", out_valid_s); end
      if (in_ready_s !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got %b exp 1", in_ready_s); end
      @(negedge clk);
      n_checks++;
      if (out_valid_s !== 1'b0) begin n_fail++; $display("FAIL bp_no_accept got %b exp 0", out_valid_s); end
   endtask

   task automatic test_reset_mid_acc();
      int lat;
      @(negedge clk);
      in_a     = 4'h7;
      in_b     = 4'h7;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks += 4;
      if (row0_s !== 8'h00) begin n_fail++; $display("FAIL midrst_row0 got %h exp 00", row0_s); end
      if (row1_s !== 8'h00) begin n_fail++; $display("FAIL midrst_row1 got %h exp 00", row1_s); end
      if (out_valid_s !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b exp 0", out_valid_s); end
      if (in_ready_s !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got %b exp 1", in_ready_s); end
      run_op(4'h6, 4'hD, lat);  // 6*-3 = -18, 6*13 = 78
      n_checks += 3;
      if (lat !== 4) begin n_fail++; $display("FAIL midrst_latency got %0d exp 4", lat); end
      if (sum_s !== 8'hEE) begin n_fail++; $display("FAIL midrst_sum_s got %h exp ee", sum_s); end
      if (sum_u !== 8'h4E) begin n_fail++; $display("FAIL midrst_sum_u got %h exp 4e", sum_u); end
      release_op();
   endtask

   task automatic test_input_change();
      @(negedge clk);
      in_a     = 4'h5;
      in_b     = 4'hD;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_a = 4'(i * 3 + 1);
         in_b = 4'(15 - i);
      end
      n_checks += 3;
      if (out_valid_s !== 1'b1) begin n_fail++; $display("FAIL chg_valid got %b exp 1", out_valid_s); end
      if (sum_s !== 8'hF1) begin n_fail++; $display("FAIL chg_sum_s got %h exp f1", sum_s); end
      if (sum_u !== 8'h41) begin n_fail++; $display("FAIL chg_sum_u got %h exp 41", sum_u); end
      in_valid = 1'b0;
      release_op();
   endtask

   task automatic test_back_to_back();
      int lat;
      out_ready = 1'b1;
      run_op(4'h9, 4'h2, lat);  // -7*2 = -14, 9*2 = 18
      n_checks += 3;
      if (sum_s !== 8'hF2) begin n_fail++; $display("FAIL b2b0_sum_s got %h exp f2", sum_s); end
      if (sum_u !== 8'h12) begin n_fail++; $display("FAIL b2b0_sum_u got %h exp 12", sum_u); end
      if (lat !== 4) begin n_fail++; $display("FAIL b2b0_latency got %0d exp 4", lat); end
      @(negedge clk);
      n_checks++;
      if (in_ready_s !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready got %b exp 1", in_ready_s); end
      run_op(4'hC, 4'hC, lat);  // -4*-4 = 16, 12*12 = 144
      n_checks += 2;
      if (sum_s !== 8'h10) begin n_fail++; $display("FAIL b2b1_sum_s got %h exp 10", sum_s); end
      if (sum_u !== 8'h90) begin n_fail++; $display("FAIL b2b1_sum_u got %h exp 90", sum_u); end
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_exhaustive();
      logic [7:0] iv;
      logic [7:0] es, eu;
      int lat;
      for (int i = 0; i < 256; i++) begin
         iv = i[7:0];
         es = ref_prod(iv[7:4], iv[3:0], 1'b1);
         eu = ref_prod(iv[7:4], iv[3:0], 1'b0);
         run_op(iv[7:4], iv[3:0], lat);
         n_checks += 4;
         if (sum_s !== es) begin n_fail++; $display("FAIL exh_s a=%h b=%h got %h exp %h", iv[7:4], iv[3:0], sum_s, es); end
         if (sum_u !== eu) begin n_fail++; $display("FAIL exh_u a=%h b=%h got %h exp %h", iv[7:4], iv[3:0], sum_u, eu); end
         if (row1_s[0] !== 1'b0) begin n_fail++; $display("FAIL exh_lsb_s a=%h b=%h got %b exp 0", iv[7:4], iv[3:0], row1_s[0]); end
         if (row1_u[0] !== 1'b0) begin n_fail++; $display("FAIL exh_lsb_u a=%h b=%h got %b exp 0", iv[7:4], iv[3:0], row1_u[0]); end
         release_op();
      end
   endtask

   initial begin
      test_reset();
      test_signed_vectors();
      test_unsigned_vectors();
      test_backpressure();
      test_reset_mid_acc();
      test_input_change();
      test_back_to_back();
      test_exhaustive();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
